image_mem_arbiter: RTL

Two-port arbiter sharing the single-port image memory (8-bit pixels, 152100 words, combinational read, write on rising clock edge) between the processor load/store port (M0) and the pixel-processing engine (M1). It uses round-robin arbitration with a bounded burst length, so a streaming requester keeps the memory for several consecutive cycles without starving the other. It also registers read data and range-checks addresses.

---
 rtl/image_mem_pkg.sv | 18 +
 rtl/rr_burst_arb.sv | 66 ++++++
 rtl/image_mem_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/image_mem_pkg.sv
// Shared constants and owner encoding for the image memory arbiter.
package image_mem_pkg;

    localparam int unsigned IMG_WORDS = 152100;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ADDR_W    = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    function automatic owner_e other_of(input owner_e o);
        return (o == OWN_M0) ? OWN_M1 : OWN_M0;
    endfunction

endpackage

// File: rtl/rr_burst_arb.sv
// Round-robin arbiter with bounded bursts: the owner keeps the grant until it
// has used MAX_BURST consecutive cycles while the other master is waiting.
module rr_burst_arb
    import image_mem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    owner_e             owner_q, owner_d, cand;
    owner_e             rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               burst_left;

    always_comb begin
        cand       = OWN_NONE;
        burst_left = (cnt_q < CNT_W'(MAX_BURST));
        case (owner_q)
            OWN_M0: begin
                if (req[0] && (burst_left || !req[1])) cand = OWN_M0;
                else if (req[1])                       cand = OWN_M1;
            end
            OWN_M1: begin
                if (req[1] && (burst_left || !req[0])) cand = OWN_M1;
                else if (req[0])                       cand = OWN_M0;
            end
            default: begin
                if (req[0] && req[1]) cand = rr_q;
                else if (req[0])      cand = OWN_M0;
                else if (req[1])      cand = OWN_M1;
            end
        endcase

        // Grants are suppressed while reset is held, even though req may be high.
        gnt = {(cand == OWN_M1), (cand == OWN_M0)} & {2{RST_N}};

        owner_d = cand;
        rr_d    = rr_q;
        cnt_d   = '0;
        if (cand != OWN_NONE) begin
            rr_d = other_of(cand);
            if (cand != owner_q)                     cnt_d = CNT_W'(1);
            else if (cnt_q == CNT_W'(MAX_BURST))     cnt_d = cnt_q;
            else                                     cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner_q <= OWN_NONE;
            rr_q    <= OWN_M0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/image_mem_arbiter.sv
// Shares the single-port image memory between M0 and M1: address mux,
// range check and per-master registered read return.
module image_mem_arbiter #(
    parameter int unsigned IMG_WORDS = image_mem_pkg::IMG_WORDS,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ADDR_W    = image_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W    = image_mem_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m0_err,
    output logic              m1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    import image_mem_pkg::*;

    logic [1:0]             req, gnt;
    logic                   sel_we, in_range;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wd;

    logic [1:0]             rvalid_q, rvalid_d, err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    assign req = {m1_req, m0_req};

    rr_burst_arb #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (req),
        .gnt   (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_wd   = '0;
        if (gnt[1]) begin
            sel_we   = m1_we;
            sel_addr = m1_addr;
            sel_wd   = m1_wdata;
        end else if (gnt[0]) begin
            sel_we   = m0_we;
            sel_addr = m0_addr;
            sel_wd   = m0_wdata;
        end
        in_range = (sel_addr < ADDR_W'(IMG_WORDS));
    end

    // Out-of-range writes still take their grant cycle but never reach memory.
    assign mem_we = (|gnt) & sel_we & in_range;
    assign mem_a  = sel_addr;
    assign mem_wd = sel_wd;

    always_comb begin
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (gnt[i]) begin
                rvalid_d[i] = !sel_we || !in_range;
                err_d[i]    = !in_range;
                if (!in_range)    rdata_d[i] = '0;
                else if (!sel_we) rdata_d[i] = mem_rd;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];

endmodule
